// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity mode encodings, line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP1  = 3'd5,
        STOP2  = 3'd6
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit generator shared by the UART TX and RX paths.
// Even mode returns the XOR of the data bits, odd mode its inverse.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_odd,
    output logic                  o_parity
);

    // Reduce the word to one bit and flip it for odd parity
    always_comb begin
        o_parity = (i_par_odd == PAR_ODD) ? ~(^i_data) : (^i_data);
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one or two stop bits, paced by an external baud tick. Registered TX line.
// Build option UART_TX_HOLD_EN adds a one-word holding register so the next frame
// can be queued during a transmission and started back-to-back.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_baud_tick,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_odd,
    input  logic                  i_stop2,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_tx_out
);

    tx_state_t             state_q;
    logic [CNT_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  stop2_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  xfer;
    logic                  parity_bit;
    logic                  last_idx;
    logic                  frame_end;
    logic                  next_bit;
    logic [CNT_WIDTH-1:0]  idx_nxt;

`ifdef UART_TX_HOLD_EN
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_par_en_q;
    logic                  hold_par_odd_q;
    logic                  hold_stop2_q;
    logic                  hold_full_q;

    logic                  chain;
    logic [DATA_WIDTH-1:0] nx_data;
    logic                  nx_par_en;
    logic                  nx_par_odd;
    logic                  nx_stop2;

    assign o_ready = !hold_full_q;

    // Source of the following frame at end of frame: held word, else a word arriving now
    always_comb begin
        chain = hold_full_q || xfer;
        if (hold_full_q) begin
            nx_data    = hold_data_q;
            nx_par_en  = hold_par_en_q;
            nx_par_odd = hold_par_odd_q;
            nx_stop2   = hold_stop2_q;
        end else begin
            nx_data    = i_data;
            nx_par_en  = i_par_en;
            nx_par_odd = i_par_odd;
            nx_stop2   = i_stop2;
        end
    end
`else
    assign o_ready = (state_q == IDLE);
`endif

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_tx_out = tx_q;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (data_q),
        .i_par_odd (par_odd_q),
        .o_parity  (parity_bit)
    );

    // Handshake, bit selection and end-of-frame detection from the registered state
    always_comb begin
        xfer      = i_data_valid && o_ready;
        idx_nxt   = idx_q + CNT_WIDTH'(1);
        next_bit  = |(data_q & (DATA_WIDTH'(1) << idx_nxt));
        last_idx  = (idx_q == CNT_WIDTH'(DATA_WIDTH - 1));
        frame_end = i_baud_tick && (((state_q == STOP1) && !stop2_q) || (state_q == STOP2));
    end

    // Frame sequencer; the line value is registered alongside each state change
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_data_q    <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_odd_q <= 1'b0;
            hold_stop2_q   <= 1'b0;
            hold_full_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (frame_end) begin
                done_q <= 1'b1;
`ifdef UART_TX_HOLD_EN
                if (chain) begin
                    // Start bit goes out on this same tick: no idle bit between frames
                    state_q     <= START;
                    tx_q        <= 1'b0;
                    data_q      <= nx_data;
                    par_en_q    <= nx_par_en;
                    par_odd_q   <= nx_par_odd;
                    stop2_q     <= nx_stop2;
                    hold_full_q <= 1'b0;
                end else begin
                    state_q <= IDLE;
                    tx_q    <= LINE_IDLE;
                    busy_q  <= 1'b0;
                end
`else
                state_q <= IDLE;
                tx_q    <= LINE_IDLE;
                busy_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (xfer) begin
                            data_q    <= i_data;
                            par_en_q  <= i_par_en;
                            par_odd_q <= i_par_odd;
                            stop2_q   <= i_stop2;
                            busy_q    <= 1'b1;
                            state_q   <= PEND;
                        end
                    end
                    PEND: begin
                        if (i_baud_tick) begin
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end
                    end
                    START: begin
                        if (i_baud_tick) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                            tx_q    <= data_q[0];
                        end
                    end
                    DATA: begin
                        if (i_baud_tick) begin
                            if (last_idx) begin
                                if (par_en_q) begin
                                    state_q <= PARITY;
                                    tx_q    <= parity_bit;
                                end else begin
                                    state_q <= STOP1;
                                    tx_q    <= LINE_IDLE;
                                end
                            end else begin
                                idx_q <= idx_nxt;
                                tx_q  <= next_bit;
                            end
                        end
                    end
                    PARITY: begin
                        if (i_baud_tick) begin
                            state_q <= STOP1;
                            tx_q    <= LINE_IDLE;
                        end
                    end
                    STOP1: begin
                        if (i_baud_tick) begin
                            state_q <= STOP2;
                            tx_q    <= LINE_IDLE;
                        end
                    end
                    STOP2: begin
                        tx_q <= LINE_IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= LINE_IDLE;
                        busy_q  <= 1'b0;
`ifdef UART_TX_HOLD_EN
                        hold_full_q <= 1'b0;
`endif
                    end
                endcase
`ifdef UART_TX_HOLD_EN
                if (xfer && (state_q inside {PEND, START, DATA, PARITY, STOP1, STOP2})) begin
                    hold_data_q    <= i_data;
                    hold_par_en_q  <= i_par_en;
                    hold_par_odd_q <= i_par_odd;
                    hold_stop2_q   <= i_stop2;
                    hold_full_q    <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: the driver pushes the expected bit sequence of
// every accepted word; a monitor rebuilds frames from the line at each baud tick and
// compares them when o_done pulses. Honours UART_TX_HOLD_EN when defined.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         tick;
    logic [W-1:0] data;
    logic         valid;
    logic         par_en;
    logic         par_odd;
    logic         stop2;
    logic         ready;
    logic         busy;
    logic         done;
    logic         tx;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    frame_t      exp_q[$];
    int          outstanding = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          collecting = 1'b0;
    int          coll_n = 0;
    logic [15:0] coll_bits = '0;

    uart_tx_frame #(
        .DATA_WIDTH (W),
        .CNT_WIDTH  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_baud_tick  (tick),
        .i_data       (data),
        .i_data_valid (valid),
        .i_par_en     (par_en),
        .i_par_odd    (par_odd),
        .i_stop2      (stop2),
        .o_ready      (ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_tx_out     (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-cycle baud ticks separated by 1..3 idle cycles
    initial begin
        tick = 1'b0;
        forever begin
            repeat ($urandom_range(3, 1)) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, failed=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: list the line level of each bit period of one frame
    function automatic frame_t model(input logic [W-1:0] d, input logic pe, input logic po,
                                     input logic s2);
        frame_t f;
        int     ones;
        logic   even_bit;
        f.bits = '0;
        f.n    = 1;
        ones   = 0;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                f.bits[4'(f.n)] = 1'b1;
                ones++;
            end
            f.n++;
        end
        if (pe) begin
            even_bit = ((ones % 2) != 0);
            f.bits[4'(f.n)] = (po == PAR_ODD) ? !even_bit : even_bit;
            f.n++;
        end
        f.bits[4'(f.n)] = 1'b1;
        f.n++;
        if (s2) begin
            f.bits[4'(f.n)] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    function automatic logic exp_ready();
`ifdef UART_TX_HOLD_EN
        return outstanding < 2;
`else
        return outstanding == 0;
`endif
    endfunction

    // Monitor: rebuild frames from the line after every tick and score them on o_done
    initial begin : monitor
        bit     t;
        bit     r;
        logic   done_prev;
        logic   tx_prev;
        frame_t e;
        done_prev = 1'b0;
        tx_prev   = 1'b1;
        forever begin
            @(posedge clk);
            t = tick;
            r = rst_n;
            #1;
            if (!r) begin
                collecting = 1'b0;
                coll_n     = 0;
                tx_prev    = tx;
                done_prev  = done;
                continue;
            end
            if (done === 1'b1) begin
                chk("done_single_cycle", done_prev, 1'b0);
                chk("done_has_expected_frame", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    outstanding--;
                    chk("frame_started", collecting, 1'b1);
                    chk("frame_len", coll_n, e.n);
                    chk("frame_bits", coll_bits, e.bits);
                    chk("busy_at_done", busy, outstanding > 0);
`ifdef UART_TX_HOLD_EN
                    if (outstanding > 0) chk("b2b_start_same_tick", tx, 1'b0);
`endif
                end
                collecting = 1'b0;
            end
            if (t) begin
                if (collecting) begin
                    if (coll_n < 16) begin
                        coll_bits[4'(coll_n)] = tx;
                        coll_n++;
                    end
                end else if (tx === 1'b0) begin
                    collecting = 1'b1;
                    coll_bits  = '0;
                    coll_n     = 1;
                end
            end else begin
                chk("line_stable_between_ticks", tx, tx_prev);
            end
            if (collecting) chk("busy_in_frame", busy, 1'b1);
            tx_prev   = tx;
            done_prev = done;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic pe, input logic po, input logic s2);
        logic        rdy;
        int unsigned waited;
        waited = 0;
        rdy    = 1'b0;
        @(negedge clk);
        data    = d;
        par_en  = pe;
        par_odd = po;
        stop2   = s2;
        valid   = 1'b1;
        forever begin
            chk("ready", ready, exp_ready());
            rdy = ready;
            @(posedge clk);
            if (rdy || waited > 3000) break;
            waited++;
            @(negedge clk);
        end
        if (rdy) begin
            exp_q.push_back(model(d, pe, po, s2));
            outstanding++;
        end else begin
            chk("accept_within_budget", rdy, 1'b1);
        end
        @(negedge clk);
        valid   = 1'b0;
        data    = W'($urandom);
        par_en  = 1'($urandom);
        par_odd = 1'($urandom);
        stop2   = 1'($urandom);
    endtask

`ifndef UART_TX_HOLD_EN
    // Requests and config churn while a frame is on the line must be ignored
    task automatic poke(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (outstanding == 0) break;
            chk("ready_while_busy", ready, exp_ready());
            valid   = 1'b1;
            data    = W'($urandom);
            par_en  = 1'($urandom);
            par_odd = 1'($urandom);
            stop2   = 1'($urandom);
        end
        valid = 1'b0;
    endtask
`endif

    task automatic drain();
        int unsigned c;
        c = 0;
        while (outstanding > 0 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin : driver
        int unsigned c;
        rst_n   = 1'b0;
        valid   = 1'b0;
        data    = '0;
        par_en  = 1'b0;
        par_odd = 1'b0;
        stop2   = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", ready, 1'b1);
        rst_n = 1'b1;

        // Idle with ticks running and no request
        repeat (40) begin
            @(negedge clk);
            chk("idle_tx", tx, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_ready", ready, 1'b1);
        end

        send(8'hA5, 1'b1, PAR_EVEN, 1'b0);
        send(8'h07, 1'b1, PAR_ODD, 1'b1);
        send(8'h07, 1'b1, PAR_EVEN, 1'b1);
        send(8'hFF, 1'b0, PAR_EVEN, 1'b0);
`ifndef UART_TX_HOLD_EN
        poke(30);
`endif
        drain();

        // Abort a frame while data bit 4 (a zero) is on the line
        send(W'($urandom) & 8'hEF, 1'($urandom), 1'($urandom), 1'($urandom));
        c = 0;
        while (!(collecting && coll_n == 6) && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("reached_data_bit4", coll_n, 6);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ready", ready, 1'b1);
        exp_q.delete();
        outstanding = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("post_abort_done", done, 1'b0);
            chk("post_abort_tx", tx, 1'b1);
        end

`ifdef UART_TX_HOLD_EN
        send(8'h55, 1'b0, PAR_EVEN, 1'b0);
        send(8'h33, 1'b0, PAR_EVEN, 1'b0);
        @(negedge clk);
        chk("hold_full_not_ready", ready, 1'b0);
        drain();
`endif

        for (int k = 0; k < 30; k++) begin
            send(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`ifndef UART_TX_HOLD_EN
            if ($urandom_range(1, 0) == 1) poke($urandom_range(20, 5));
`endif
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(10, 1)) @(negedge clk);
        end
        drain();
        repeat (10) @(negedge clk);
        chk("queue_empty_at_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
